tile_ram_arbiter: RTL and testbench
===================================

# tile_ram_arbiter

Shares the single-port 32x32x8 tile RAM (`RAM_sync`, 1-cycle synchronous read) between three requesters: the map loader (cell evaluator), the video scan-out and the game logic (pacman controller pellet/tile updates). It sequences a boot phase in which only the loader writes, then a run phase in which video reads have priority over game accesses, with a bounded-starvation override. It sits between `RAM_sync` and its three clients in the top level, replacing the `init ? {row,col} : eval` address mux.

## Interface
- `STARVE_LIMIT`, 15: consecutive cycles a pending game request may be blocked by video before it preempts one video slot (1..255).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state.
- `ld_we`, `ld_addr`, `ld_din`  in  1/10/8  loader write strobe, address `{y,x}`, data.
- `ld_done`  in  1  loader finished (level).
- `ready`  out  1  high in RUN phase.
- `vid_req`, `vid_addr`  in  1/10  video read request for this cycle, address `{row,col}`.
- `vid_data`, `vid_valid`  out  8/1  read data and qualifier, one cycle after a granted `vid_req`.
- `vid_miss`  out  1  pulse, cycle after a `vid_req` that was not granted.
- `gm_req`, `gm_we`, `gm_addr`, `gm_wdata`  in  1/1/10/8  game access request; held stable until `gm_ack`.
- `gm_ack`  out  1  pulse in the grant cycle.
- `gm_rdata`, `gm_rvalid`  out  8/1  read data/qualifier, one cycle after a granted read.
- `miss_count`  out  8  saturating count of `vid_miss` pulses since reset.
- `ram_addr`, `ram_din`, `ram_we`  out  10/8/1  to `RAM_sync`.
- `ram_dout`  in  8  from `RAM_sync`.

## Operation
- Phase FSM: INIT -> RUN on first cycle `ld_done`=1; RUN is terminal until reset.
- INIT: `ram_addr/din/we` follow `ld_addr/ld_din/ld_we` combinationally; video and game never granted; `vid_req` produces `vid_miss`; `gm_req` waits (no ack). `ld_we` in the same cycle `ld_done` rises is still written.
- RUN: loader inputs ignored. Per cycle grant: if `gm_req` and starve counter == `STARVE_LIMIT` -> game; else if `vid_req` -> video; else if `gm_req` -> game; else none (`ram_we`=0, address holds last value).
- Starve counter (8 bit): increments each cycle `gm_req`=1 and not granted, saturates at `STARVE_LIMIT`; clears on `gm_ack` or when `gm_req`=0.
- Grant drives `ram_addr/din/we` combinationally from the winner; `ram_din`=`gm_wdata`, `ram_we`=`gm_we` for game, `ram_we`=0 for video.
- Registered read tag {VID, GM, NONE} captures the grant; next cycle `ram_dout` is routed to `vid_data` (with `vid_valid`) or `gm_rdata` (with `gm_rvalid`). Game writes produce no `gm_rvalid`.
- `vid_data`/`gm_rdata` hold last value when their valid is low.

## Timing
- Reset values: phase INIT, `ready`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, all valids/acks/miss=0, `vid_data`=`gm_rdata`=0, `miss_count`=0, starve=0, tag NONE.
- Reset asserted mid-access: pending read data discarded, no valid emitted after release.
- Read latency 1 cycle grant->valid for both clients; write committed at the grant edge.
- Game back-to-back: requester may present the next request the cycle after `gm_ack`; one access per cycle max.
- `ready` rises the cycle after `ld_done` is sampled high.
- `miss_count` stops at 255.

## Structure
- Shared package/include: phase encoding (INIT, RUN) and tag encoding (NONE, VID, GM); RAM address width 10, data width 8.
- Single module; no sub-module needed (the starve counter is inline).

## Test plan
- Reset, loader writes 0x05 to 0x000 and 0x1F to 0x3FF, `ld_done` -> `ready`=1 next cycle; video reads of 0x000/0x3FF return 0x05/0x1F with `vid_valid` one cycle later.
- `vid_req` and `gm_req` during INIT -> `vid_miss` pulses, `miss_count`=1, no `gm_ack` until RUN.
- RUN, simultaneous `vid_req` and game read of 0x021 -> video granted; game acked first idle cycle, `gm_rdata` valid next cycle.
- `vid_req` held high continuously, game write 0x00 to 0x045 pending, `STARVE_LIMIT`=15 -> `gm_ack` on 16th cycle, `vid_miss` the cycle after, later read of 0x045 returns 0x00.
- Reset asserted in the cycle after a granted game read -> no `gm_rvalid`, all outputs at reset values, phase INIT.
- 300 missed video requests -> `miss_count` saturates at 255.

Source files
------------

// File: rtl/tile_ram_arbiter_pkg.sv
// Shared types and constants for the tile RAM arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: RAM geometry, phase / grant / read-tag encodings, saturating increment helper.
package tile_ram_arbiter_pkg;

    localparam int ADDR_W = 10;  // 32x32 tiles, address {y,x} / {row,col}
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [7:0]        count_t;

    typedef enum logic {
        PH_INIT = 1'b0,
        PH_RUN  = 1'b1
    } phase_t;

    // Who owns the RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_VID  = 2'd2,
        GNT_GM   = 2'd3
    } grant_t;

    // Which client the RAM read data belongs to on the following cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_GM   = 2'd2
    } tag_t;

    function automatic count_t sat_inc(input count_t v, input count_t lim);
        return (v >= lim) ? lim : count_t'(v + 8'd1);
    endfunction

endpackage

// File: rtl/tile_ram_arbiter_if.sv
// Bundle of loader, video, game and RAM-side signals around the tile RAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: game side holds its request until gm_ack; video and loader are never stalled.
// Modports: slave = arbiter view, master = client/RAM view.
import tile_ram_arbiter_pkg::*;

interface tile_ram_arbiter_if;

    // loader
    logic   ld_we;
    addr_t  ld_addr;
    data_t  ld_din;
    logic   ld_done;
    logic   ready;
    // video scan-out
    logic   vid_req;
    addr_t  vid_addr;
    data_t  vid_data;
    logic   vid_valid;
    logic   vid_miss;
    // game logic
    logic   gm_req;
    logic   gm_we;
    addr_t  gm_addr;
    data_t  gm_wdata;
    logic   gm_ack;
    data_t  gm_rdata;
    logic   gm_rvalid;
    count_t miss_count;
    // RAM port
    addr_t  ram_addr;
    data_t  ram_din;
    logic   ram_we;
    data_t  ram_dout;

    modport slave (
        input  ld_we, ld_addr, ld_din, ld_done,
        input  vid_req, vid_addr,
        input  gm_req, gm_we, gm_addr, gm_wdata,
        input  ram_dout,
        output ready, vid_data, vid_valid, vid_miss,
        output gm_ack, gm_rdata, gm_rvalid, miss_count,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output ld_we, ld_addr, ld_din, ld_done,
        output vid_req, vid_addr,
        output gm_req, gm_we, gm_addr, gm_wdata,
        output ram_dout,
        input  ready, vid_data, vid_valid, vid_miss,
        input  gm_ack, gm_rdata, gm_rvalid, miss_count,
        input  ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/tile_ram_arbiter.sv
// Arbitrates the single-port tile RAM: loader-only boot phase, then video-over-game with starvation override.
// Latency: grant and RAM drive are combinational; read data/valid one cycle after grant; vid_miss one cycle after a lost request.
// Backpressure: video is never stalled (lost requests flagged via vid_miss); game request is held until gm_ack.
// Ports: clk, reset (async active-low), bus (tile_ram_arbiter_if.slave).
module tile_ram_arbiter
    import tile_ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 15  // 1..255
)(
    input  logic               clk,
    input  logic               reset,
    tile_ram_arbiter_if.slave  bus
);

    localparam count_t LIMIT = count_t'(STARVE_LIMIT);

    phase_t phase_q, phase_d;
    grant_t grant;
    tag_t   tag_q;
    count_t starve_q;
    count_t miss_q;
    logic   vid_miss_q;
    addr_t  last_addr_q;
    data_t  last_din_q;
    data_t  vid_hold_q, gm_hold_q;

    addr_t  ram_addr_c;
    data_t  ram_din_c;
    logic   ram_we_c;
    logic   gm_grant;
    logic   vid_grant;
    logic   vid_lost;
    data_t  vid_data_c, gm_rdata_c;

    // Phase register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_INIT;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Next phase and per-cycle grant
    always_comb begin
        phase_d = phase_q;
        grant   = GNT_NONE;
        case (phase_q)
            PH_INIT: begin
                grant = GNT_LD;
                if (bus.ld_done) begin
                    phase_d = PH_RUN;
                end
            end
            PH_RUN: begin
                // A game request blocked for STARVE_LIMIT cycles steals one video slot.
                if (bus.gm_req && (starve_q == LIMIT)) begin
                    grant = GNT_GM;
                end else if (bus.vid_req) begin
                    grant = GNT_VID;
                end else if (bus.gm_req) begin
                    grant = GNT_GM;
                end
            end
            default: phase_d = PH_INIT;
        endcase
    end

    // RAM port mux; when idle the address and data park on their last values.
    always_comb begin
        ram_addr_c = last_addr_q;
        ram_din_c  = last_din_q;
        ram_we_c   = 1'b0;
        case (grant)
            GNT_LD: begin
                ram_addr_c = bus.ld_addr;
                ram_din_c  = bus.ld_din;
                ram_we_c   = bus.ld_we;
            end
            GNT_VID: begin
                ram_addr_c = bus.vid_addr;
            end
            GNT_GM: begin
                ram_addr_c = bus.gm_addr;
                ram_din_c  = bus.gm_wdata;
                ram_we_c   = bus.gm_we;
            end
            default: ;
        endcase
    end

    assign gm_grant  = (grant == GNT_GM);
    assign vid_grant = (grant == GNT_VID);
    assign vid_lost  = bus.vid_req && !vid_grant;

    // Data returned by the RAM belongs to whoever the tag names; otherwise hold.
    assign vid_data_c = (tag_q == TAG_VID) ? bus.ram_dout : vid_hold_q;
    assign gm_rdata_c = (tag_q == TAG_GM)  ? bus.ram_dout : gm_hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q       <= TAG_NONE;
            starve_q    <= '0;
            miss_q      <= '0;
            vid_miss_q  <= 1'b0;
            last_addr_q <= '0;
            last_din_q  <= '0;
            vid_hold_q  <= '0;
            gm_hold_q   <= '0;
        end else begin
            if (vid_grant) begin
                tag_q <= TAG_VID;
            end else if (gm_grant && !bus.gm_we) begin
                tag_q <= TAG_GM;
            end else begin
                tag_q <= TAG_NONE;
            end

            if (!bus.gm_req || gm_grant) begin
                starve_q <= '0;
            end else begin
                starve_q <= sat_inc(starve_q, LIMIT);
            end

            vid_miss_q <= vid_lost;
            if (vid_lost) begin
                miss_q <= sat_inc(miss_q, 8'hFF);
            end

            last_addr_q <= ram_addr_c;
            last_din_q  <= ram_din_c;
            vid_hold_q  <= vid_data_c;
            gm_hold_q   <= gm_rdata_c;
        end
    end

    assign bus.ready      = (phase_q == PH_RUN);
    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_din    = ram_din_c;
    assign bus.ram_we     = ram_we_c;
    assign bus.gm_ack     = gm_grant;
    assign bus.vid_valid  = (tag_q == TAG_VID);
    assign bus.vid_data   = vid_data_c;
    assign bus.gm_rvalid  = (tag_q == TAG_GM);
    assign bus.gm_rdata   = gm_rdata_c;
    assign bus.vid_miss   = vid_miss_q;
    assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Self-checking bench for tile_ram_arbiter with a synchronous RAM model and a reference model.
// Latency: checks sampled 1 time unit after each falling edge, where inputs for the cycle are applied.
// Backpressure: game stimulus holds each request until the reference model grants it.
module tb_tile_ram_arbiter;
    import tile_ram_arbiter_pkg::*;

    localparam int LIMIT = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tile_ram_arbiter_if bus();

    tile_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [7:0] seed_val(input int a);
        return 8'((a * 29 + (a >> 3) + 7) & 255);
    endfunction

    // Synchronous single-port RAM, 1-cycle read latency, read-before-write.
    logic [7:0] ram_mem [1024];
    bit ram_seeded = 1'b0;
    always @(posedge clk) begin
        logic [7:0] rd;
        if (!ram_seeded) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] = seed_val(i);
            ram_seeded = 1'b1;
        end
        rd = ram_mem[bus.ram_addr];
        if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_din;
        bus.ram_dout <= rd;
    end

    // Reference model: tile contents plus the externally visible arbiter behaviour.
    logic [7:0] m_mem [1024];
    bit   m_seeded = 1'b0;
    bit   m_run;
    int   m_starve;
    int   m_miss;
    bit   m_vid_valid, m_gm_rvalid, m_vid_miss;
    logic [7:0] m_vid_data, m_gm_rdata;

    // 0 = nobody, 1 = video, 2 = game, for the inputs currently applied.
    function automatic int who_wins();
        if (!m_run) return 0;
        if (bus.gm_req && m_starve == LIMIT) return 2;
        if (bus.vid_req) return 1;
        if (bus.gm_req) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        int g;
        if (!m_seeded) begin
            for (int i = 0; i < 1024; i++) m_mem[i] = seed_val(i);
            m_seeded = 1'b1;
        end
        if (!reset) begin
            m_run = 0; m_starve = 0; m_miss = 0;
            m_vid_valid = 0; m_gm_rvalid = 0; m_vid_miss = 0;
            m_vid_data = 8'h00; m_gm_rdata = 8'h00;
        end else begin
            g = who_wins();
            m_vid_valid = (g == 1);
            m_gm_rvalid = (g == 2) && !bus.gm_we;
            m_vid_miss  = bus.vid_req && (g != 1);
            if (g == 1) m_vid_data = m_mem[bus.vid_addr];
            if (m_gm_rvalid) m_gm_rdata = m_mem[bus.gm_addr];
            if (g == 2 && bus.gm_we) m_mem[bus.gm_addr] = bus.gm_wdata;
            if (!m_run && bus.ld_we) m_mem[bus.ld_addr] = bus.ld_din;
            if (m_vid_miss && m_miss < 255) m_miss++;
            if (!bus.gm_req || g == 2) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (!m_run && bus.ld_done) m_run = 1;
        end
    end

    task automatic idle_inputs();
        bus.ld_we = 0; bus.ld_addr = '0; bus.ld_din = '0; bus.ld_done = 0;
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.gm_req = 0; bus.gm_we = 0; bus.gm_addr = '0; bus.gm_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
        n_cmp++; if (bus.ram_addr !== 10'h000) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 000", bus.ram_addr); end
        n_cmp++; if (bus.ram_din !== 8'h00) begin n_fail++; $display("FAIL reset_ram_din: got %h want 00", bus.ram_din); end
        n_cmp++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vid_valid: got %b want 0", bus.vid_valid); end
        n_cmp++; if (bus.gm_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_gm_rvalid: got %b want 0", bus.gm_rvalid); end
        n_cmp++; if (bus.gm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_gm_ack: got %b want 0", bus.gm_ack); end
        n_cmp++; if (bus.vid_miss !== 1'b0) begin n_fail++; $display("FAIL reset_vid_miss: got %b want 0", bus.vid_miss); end
        n_cmp++; if (bus.vid_data !== 8'h00) begin n_fail++; $display("FAIL reset_vid_data: got %h want 00", bus.vid_data); end
        n_cmp++; if (bus.gm_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_gm_rdata: got %h want 00", bus.gm_rdata); end
        n_cmp++; if (bus.miss_count !== 8'h00) begin n_fail++; $display("FAIL reset_miss_count: got %0d want 0", bus.miss_count); end
    endtask

    task automatic test_init_phase();
        @(negedge clk);
        reset = 1;
        bus.ld_we = 1; bus.ld_addr = 10'h000; bus.ld_din = 8'h05;
        bus.vid_req = 1; bus.vid_addr = 10'h010;
        bus.gm_req = 1; bus.gm_we = 0; bus.gm_addr = 10'h021;
        #1;
        n_cmp++; if (bus.gm_ack !== 1'b0) begin n_fail++; $display("FAIL init_no_ack0: got %b want 0", bus.gm_ack); end
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL init_ld_we: got %b want 1", bus.ram_we); end
        n_cmp++; if (bus.ram_din !== 8'h05) begin n_fail++; $display("FAIL init_ld_din: got %h want 05", bus.ram_din); end
        @(negedge clk);
        bus.ld_addr = 10'h3FF; bus.ld_din = 8'h1F; bus.ld_done = 1;
        bus.vid_req = 0;
        #1;
        n_cmp++; if (bus.vid_miss !== 1'b1) begin n_fail++; $display("FAIL init_vid_miss: got %b want 1", bus.vid_miss); end
        n_cmp++; if (bus.miss_count !== 8'd1) begin n_fail++; $display("FAIL init_miss_count: got %0d want 1", bus.miss_count); end
        n_cmp++; if (bus.gm_ack !== 1'b0) begin n_fail++; $display("FAIL init_no_ack1: got %b want 0", bus.gm_ack); end
        n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_early: got %b want 0", bus.ready); end
        n_cmp++; if (bus.ram_addr !== 10'h3FF) begin n_fail++; $display("FAIL init_ld_addr: got %h want 3ff", bus.ram_addr); end
        @(negedge clk);
        bus.ld_we = 0; bus.ld_addr = '0; bus.ld_din = '0; bus.ld_done = 0;
        #1;
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL init_ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.gm_ack !== 1'b1) begin n_fail++; $display("FAIL run_first_ack: got %b want 1", bus.gm_ack); end
        n_cmp++; if (bus.ram_addr !== 10'h021) begin n_fail++; $display("FAIL run_gm_addr: got %h want 021", bus.ram_addr); end
        @(negedge clk);
        bus.gm_req = 0;
        #1;
        n_cmp++; if (bus.gm_rvalid !== 1'b1) begin n_fail++; $display("FAIL run_gm_rvalid: got %b want 1", bus.gm_rvalid); end
        n_cmp++; if (bus.gm_rdata !== seed_val(10'h021)) begin n_fail++; $display("FAIL run_gm_rdata: got %h want %h", bus.gm_rdata, seed_val(10'h021)); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.vid_req = 1; bus.vid_addr = 10'h000;
        bus.gm_req = 1; bus.gm_we = 0; bus.gm_addr = 10'h021;
        #1;
        n_cmp++; if (bus.gm_ack !== 1'b0) begin n_fail++; $display("FAIL prio_vid_wins: got ack %b want 0", bus.gm_ack); end
        n_cmp++; if (bus.ram_addr !== 10'h000) begin n_fail++; $display("FAIL prio_addr: got %h want 000", bus.ram_addr); end
        @(negedge clk);
        bus.vid_req = 0;
        #1;
        n_cmp++; if (bus.vid_valid !== 1'b1) begin n_fail++; $display("FAIL prio_vid_valid: got %b want 1", bus.vid_valid); end
        n_cmp++; if (bus.vid_data !== 8'h05) begin n_fail++; $display("FAIL prio_vid_data0: got %h want 05", bus.vid_data); end
        n_cmp++; if (bus.gm_ack !== 1'b1) begin n_fail++; $display("FAIL prio_gm_ack_idle: got %b want 1", bus.gm_ack); end
        @(negedge clk);
        bus.gm_req = 0; bus.vid_req = 1; bus.vid_addr = 10'h3FF;
        #1;
        n_cmp++; if (bus.gm_rvalid !== 1'b1) begin n_fail++; $display("FAIL prio_gm_rvalid: got %b want 1", bus.gm_rvalid); end
        n_cmp++; if (bus.gm_rdata !== seed_val(10'h021)) begin n_fail++; $display("FAIL prio_gm_rdata: got %h want %h", bus.gm_rdata, seed_val(10'h021)); end
        n_cmp++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL prio_vid_valid_low: got %b want 0", bus.vid_valid); end
        @(negedge clk);
        bus.vid_req = 0;
        #1;
        n_cmp++; if (bus.vid_data !== 8'h1F) begin n_fail++; $display("FAIL vid_data_3ff: got %h want 1f", bus.vid_data); end
        @(negedge clk); #1;
        n_cmp++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL vid_valid_drop: got %b want 0", bus.vid_valid); end
        n_cmp++; if (bus.vid_data !== 8'h1F) begin n_fail++; $display("FAIL vid_data_hold: got %h want 1f", bus.vid_data); end
    endtask

    task automatic test_starve();
        int ack_cycle = 0;
        @(negedge clk);
        bus.vid_req = 1; bus.vid_addr = 10'h100;
        bus.gm_req = 1; bus.gm_we = 1; bus.gm_addr = 10'h045; bus.gm_wdata = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (bus.gm_ack === 1'b1) begin
                ack_cycle = c;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (ack_cycle != LIMIT + 1) begin n_fail++; $display("FAIL starve_ack_cycle: got %0d want %0d", ack_cycle, LIMIT + 1); end
        @(negedge clk);
        bus.gm_req = 0; bus.gm_we = 0; bus.vid_addr = 10'h045;
        #1;
        n_cmp++; if (bus.vid_miss !== 1'b1) begin n_fail++; $display("FAIL starve_vid_miss: got %b want 1", bus.vid_miss); end
        n_cmp++; if (bus.miss_count !== 8'd2) begin n_fail++; $display("FAIL starve_miss_count: got %0d want 2", bus.miss_count); end
        n_cmp++; if (bus.gm_rvalid !== 1'b0) begin n_fail++; $display("FAIL starve_write_no_rvalid: got %b want 0", bus.gm_rvalid); end
        @(negedge clk);
        bus.vid_req = 0;
        #1;
        n_cmp++; if (bus.vid_valid !== 1'b1) begin n_fail++; $display("FAIL starve_readback_valid: got %b want 1", bus.vid_valid); end
        n_cmp++; if (bus.vid_data !== 8'h00) begin n_fail++; $display("FAIL starve_readback_data: got %h want 00", bus.vid_data); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.gm_req = 1; bus.gm_we = 0; bus.gm_addr = 10'h021; bus.vid_req = 0;
        #1;
        n_cmp++; if (bus.gm_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %b want 1", bus.gm_ack); end
        @(posedge clk); #1;
        reset = 0; bus.gm_req = 0;
        #1;
        n_cmp++; if (bus.gm_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b want 0", bus.gm_rvalid); end
        n_cmp++; if (bus.gm_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 00", bus.gm_rdata); end
        n_cmp++; if (bus.vid_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_vid_data: got %h want 00", bus.vid_data); end
        n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", bus.ready); end
        n_cmp++; if (bus.miss_count !== 8'h00) begin n_fail++; $display("FAIL rstmid_miss_count: got %0d want 0", bus.miss_count); end
        n_cmp++; if (bus.ram_addr !== 10'h000) begin n_fail++; $display("FAIL rstmid_ram_addr: got %h want 000", bus.ram_addr); end
        @(negedge clk);
        reset = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.gm_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_rvalid c%0d: got %b want 0", c, bus.gm_rvalid); end
            n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_ready c%0d: got %b want 0", c, bus.ready); end
        end
    endtask

    task automatic test_miss_saturate();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.vid_req = 1; bus.vid_addr = 10'($urandom_range(0, 1023));
            #1;
            n_cmp++; if (bus.miss_count !== 8'(m_miss)) begin n_fail++; $display("FAIL sat_count c%0d: got %0d want %0d", c, bus.miss_count, m_miss); end
        end
        @(negedge clk);
        bus.vid_req = 0;
        #1;
        n_cmp++; if (bus.miss_count !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d want 255", bus.miss_count); end
        n_cmp++; if (bus.vid_miss !== 1'b1) begin n_fail++; $display("FAIL sat_vid_miss: got %b want 1", bus.vid_miss); end
    endtask

    task automatic test_random();
        bit gm_pending = 0;
        bit e_ack, e_we;
        @(negedge clk);
        reset = 0; idle_inputs();
        @(negedge clk);
        reset = 1;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (c < 20) begin
                bus.ld_we = 1'($urandom); bus.ld_addr = 10'($urandom_range(0, 63));
                bus.ld_din = 8'($urandom); bus.ld_done = (c == 19);
            end else begin
                bus.ld_we = 0; bus.ld_done = 0;
                if (!gm_pending && ($urandom_range(0, 1) == 1)) begin
                    gm_pending = 1;
                    bus.gm_we = 1'($urandom); bus.gm_addr = 10'($urandom_range(0, 63));
                    bus.gm_wdata = 8'($urandom);
                end
            end
            bus.gm_req = gm_pending;
            bus.vid_req = ($urandom_range(0, 9) < 7);
            bus.vid_addr = 10'($urandom_range(0, 63));
            #1;
            e_ack = (who_wins() == 2);
            e_we = m_run ? (e_ack && bus.gm_we) : bus.ld_we;
            n_cmp++; if (bus.gm_ack !== e_ack) begin n_fail++; $display("FAIL rnd_gm_ack c%0d: got %b want %b", c, bus.gm_ack, e_ack); end
            n_cmp++; if (bus.ram_we !== e_we) begin n_fail++; $display("FAIL rnd_ram_we c%0d: got %b want %b", c, bus.ram_we, e_we); end
            n_cmp++; if (bus.ready !== m_run) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.ready, m_run); end
            n_cmp++; if (bus.vid_valid !== m_vid_valid) begin n_fail++; $display("FAIL rnd_vid_valid c%0d: got %b want %b", c, bus.vid_valid, m_vid_valid); end
            n_cmp++; if (bus.vid_data !== m_vid_data) begin n_fail++; $display("FAIL rnd_vid_data c%0d: got %h want %h", c, bus.vid_data, m_vid_data); end
            n_cmp++; if (bus.gm_rvalid !== m_gm_rvalid) begin n_fail++; $display("FAIL rnd_gm_rvalid c%0d: got %b want %b", c, bus.gm_rvalid, m_gm_rvalid); end
            n_cmp++; if (bus.gm_rdata !== m_gm_rdata) begin n_fail++; $display("FAIL rnd_gm_rdata c%0d: got %h want %h", c, bus.gm_rdata, m_gm_rdata); end
            n_cmp++; if (bus.vid_miss !== m_vid_miss) begin n_fail++; $display("FAIL rnd_vid_miss c%0d: got %b want %b", c, bus.vid_miss, m_vid_miss); end
            n_cmp++; if (bus.miss_count !== 8'(m_miss)) begin n_fail++; $display("FAIL rnd_miss_count c%0d: got %0d want %0d", c, bus.miss_count, m_miss); end
            if (e_ack) gm_pending = 0;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init_phase();
        test_priority();
        test_starve();
        test_reset_mid();
        test_miss_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
